// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcodes,
// FSM states, instruction field slices and the per-opcode control decode.
package seq_pkg;

   localparam int SEQ_PC_W    = 4;
   localparam int SEQ_INSTR_W = 10;
   localparam int SEQ_DATA_W  = 4;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_MOVA = 4'b0001;
   localparam logic [3:0] OP_MOVB = 4'b0010;
   localparam logic [3:0] OP_OUT  = 4'b0011;
   localparam logic [3:0] OP_ADDA = 4'b0100;
   localparam logic [3:0] OP_ADDB = 4'b0101;
   localparam logic [3:0] OP_HLT  = 4'b1000;
   localparam logic [3:0] OP_JNC  = 4'b1110;
   localparam logic [3:0] OP_JMP  = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HALT
   } state_t;

   // Everything the write-back phase needs to know about one opcode.
   typedef struct packed {
      logic we_a;
      logic we_b;
      logic we_out;
      logic carry_load;
      logic carry_clr;
      logic is_jmp;
      logic is_jnc;
      logic is_hlt;
   } op_ctrl_t;

   // Instruction layout: [9:8] selector source, [7:4] opcode, [3:0] immediate.
   function automatic logic [1:0] instr_sel(input logic [SEQ_INSTR_W-1:0] ir);
      return ir[9:8];
   endfunction

   function automatic logic [3:0] instr_op(input logic [SEQ_INSTR_W-1:0] ir);
      return ir[7:4];
   endfunction

   function automatic logic [SEQ_DATA_W-1:0] instr_imm(input logic [SEQ_INSTR_W-1:0] ir);
      return ir[3:0];
   endfunction

   // Undefined opcodes decode to all-zero controls, i.e. they behave as NOP.
   function automatic op_ctrl_t decode_op(input logic [3:0] op);
      op_ctrl_t c;
      c = '0;
      case (op)
         OP_NOP:  c = '0;
         OP_MOVA: begin c.we_a   = 1'b1; c.carry_clr  = 1'b1; end
         OP_MOVB: begin c.we_b   = 1'b1; c.carry_clr  = 1'b1; end
         OP_OUT:  begin c.we_out = 1'b1; c.carry_clr  = 1'b1; end
         OP_ADDA: begin c.we_a   = 1'b1; c.carry_load = 1'b1; end
         OP_ADDB: begin c.we_b   = 1'b1; c.carry_load = 1'b1; end
         OP_JNC:  c.is_jnc = 1'b1;
         OP_JMP:  c.is_jmp = 1'b1;
         OP_HLT:  c.is_hlt = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: holds the ROM address, advances once per write-back,
// either to the jump target or to the next address (wrapping at the top).
module pc_unit #(
   parameter int PC_W = seq_pkg::SEQ_PC_W
) (
   input  logic            clk0,
   input  logic            rst,
   input  logic            advance,
   input  logic            is_jmp,
   input  logic            is_jnc,
   input  logic            carry,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   // Pick the next address: jump target for JMP or a JNC with carry clear, else pc+1.
   always_comb begin
      pc_d = pc_q;
      if (advance) begin
         if (is_jmp || (is_jnc && !carry)) begin
            pc_d = target;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   // Program counter register, cleared to the first ROM word on reset.
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 4-bit accumulator datapath.
// Each instruction takes FETCH, DECODE, EXEC and WB; the IR and carry flag
// live here, the program counter lives in pc_unit.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int PC_W    = SEQ_PC_W,
   parameter int INSTR_W = SEQ_INSTR_W,
   parameter int DATA_W  = SEQ_DATA_W
) (
   input  logic               clk0,
   input  logic               rst,
   input  logic               run,
   input  logic               step,
   input  logic [INSTR_W-1:0] instr,
   input  logic               alu_carry,
   output logic [PC_W-1:0]    pc,
   output logic               rom_en,
   output logic [1:0]         sel,
   output logic [3:0]         alu_op,
   output logic [DATA_W-1:0]  imm,
   output logic               we_a,
   output logic               we_b,
   output logic               we_out,
   output logic               carry_q,
   output logic               busy,
   output logic               halted
);

   state_t             state_q;
   state_t             state_d;
   logic [INSTR_W-1:0] ir_q;
   logic [INSTR_W-1:0] ir_d;
   logic               carry_d;

   logic [1:0]         ir_sel;
   logic [3:0]         ir_op;
   logic [DATA_W-1:0]  ir_imm;
   op_ctrl_t           ctrl;
   logic               in_wb;

   assign ir_sel = instr_sel(ir_q);
   assign ir_op  = instr_op(ir_q);
   assign ir_imm = instr_imm(ir_q);
   assign ctrl   = decode_op(ir_op);
   assign in_wb  = (state_q == ST_WB);

   // State, instruction and carry registers; reset aborts any instruction in flight.
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         carry_q <= carry_d;
      end
   end

   // Sequence the four phases; step is only looked at while idle, HALT is sticky.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (run || step) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_WB;
         ST_WB: begin
            if (ctrl.is_hlt) begin
               state_d = ST_HALT;
            end else if (run) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Capture ROM data in DECODE; update carry in WB (ADD loads it, MOV/OUT clear it).
   always_comb begin
      ir_d    = ir_q;
      carry_d = carry_q;
      if (state_q == ST_DECODE) begin
         ir_d = instr;
      end
      if (in_wb) begin
         if (ctrl.carry_load) begin
            carry_d = alu_carry;
         end else if (ctrl.carry_clr) begin
            carry_d = 1'b0;
         end
      end
   end

   // Phase-dependent outputs: ROM strobe in FETCH, datapath controls held over EXEC and WB.
   always_comb begin
      rom_en = 1'b0;
      sel    = '0;
      alu_op = '0;
      imm    = '0;
      we_a   = 1'b0;
      we_b   = 1'b0;
      we_out = 1'b0;
      busy   = 1'b0;
      halted = 1'b0;
      case (state_q)
         ST_IDLE: begin
         end
         ST_FETCH: begin
            busy   = 1'b1;
            rom_en = 1'b1;
         end
         ST_DECODE: begin
            busy = 1'b1;
         end
         ST_EXEC: begin
            busy   = 1'b1;
            sel    = ir_sel;
            alu_op = ir_op;
            imm    = ir_imm;
         end
         ST_WB: begin
            busy   = 1'b1;
            sel    = ir_sel;
            alu_op = ir_op;
            imm    = ir_imm;
            we_a   = ctrl.we_a;
            we_b   = ctrl.we_b;
            we_out = ctrl.we_out;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   pc_unit #(
      .PC_W(PC_W)
   ) u_pc_unit (
      .clk0    (clk0),
      .rst     (rst),
      .advance (in_wb),
      .is_jmp  (ctrl.is_jmp),
      .is_jnc  (ctrl.is_jnc),
      .carry   (carry_q),
      .target  (ir_imm[PC_W-1:0]),
      .pc      (pc)
   );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a random
// program, checked against an instruction-level model of the sequencer.
module tb_instr_sequencer;

   logic       clk0;
   logic       rst;
   logic       run;
   logic       step;
   logic [9:0] instr;
   logic       alu_carry;
   logic [3:0] pc;
   logic       rom_en;
   logic [1:0] sel;
   logic [3:0] alu_op;
   logic [3:0] imm;
   logic       we_a;
   logic       we_b;
   logic       we_out;
   logic       carry_q;
   logic       busy;
   logic       halted;

   int total;
   int bad;

   logic [9:0] rom [16];
   logic [3:0] m_pc;
   logic       m_carry;
   logic       m_halted;

   instr_sequencer dut (
      .clk0      (clk0),
      .rst       (rst),
      .run       (run),
      .step      (step),
      .instr     (instr),
      .alu_carry (alu_carry),
      .pc        (pc),
      .rom_en    (rom_en),
      .sel       (sel),
      .alu_op    (alu_op),
      .imm       (imm),
      .we_a      (we_a),
      .we_b      (we_b),
      .we_out    (we_out),
      .carry_q   (carry_q),
      .busy      (busy),
      .halted    (halted)
   );

   initial clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   // Synchronous ROM: data appears the cycle after the read strobe.
   initial instr = '0;
   always @(posedge clk0) begin
      if (rom_en) instr <= rom[pc];
   end

   task automatic tick;
      @(posedge clk0);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Which register an opcode writes: {we_a, we_b, we_out}.
   function automatic logic [2:0] model_we(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 3'b100;
         4'h2, 4'h5: return 3'b010;
         4'h3:       return 3'b001;
         default:    return 3'b000;
      endcase
   endfunction

   task automatic chk_idle(input string tag);
      checkOutput({tag, ":busy"},   busy, 0);
      checkOutput({tag, ":rom_en"}, rom_en, 0);
      checkOutput({tag, ":halted"}, halted, 0);
      checkOutput({tag, ":we"},     {we_a, we_b, we_out}, 0);
      checkOutput({tag, ":alu_op"}, alu_op, 0);
      checkOutput({tag, ":pc"},     pc, m_pc);
      checkOutput({tag, ":carry"},  carry_q, m_carry);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      run = 1'b0;
      step = 1'b0;
      alu_carry = 1'b0;
      tick;
      tick;
      checkOutput({tag, ":rst_pc"},    pc, 0);
      checkOutput({tag, ":rst_busy"},  busy, 0);
      checkOutput({tag, ":rst_rom"},   rom_en, 0);
      checkOutput({tag, ":rst_we"},    {we_a, we_b, we_out}, 0);
      checkOutput({tag, ":rst_carry"}, carry_q, 0);
      checkOutput({tag, ":rst_halt"},  halted, 0);
      rst = 1'b0;
      m_pc = '0;
      m_carry = 1'b0;
      m_halted = 1'b0;
      tick;
      chk_idle({tag, ":idle"});
   endtask

   // Called in the FETCH cycle; walks one instruction to its WB cycle and updates the model.
   task automatic applyStimulus(input logic cin, input logic run_after, input logic stray_step, input string tag);
      logic [9:0] w;
      logic [3:0] op;
      w  = rom[m_pc];
      op = w[7:4];
      checkOutput({tag, ":f_rom_en"}, rom_en, 1);
      checkOutput({tag, ":f_pc"},     pc, m_pc);
      checkOutput({tag, ":f_busy"},   busy, 1);
      checkOutput({tag, ":f_we"},     {we_a, we_b, we_out}, 0);
      if (stray_step) step = 1'b1;
      tick;
      checkOutput({tag, ":d_rom_en"}, rom_en, 0);
      checkOutput({tag, ":d_busy"},   busy, 1);
      step = 1'b0;
      run = run_after;
      tick;
      checkOutput({tag, ":e_sel"},    sel, w[9:8]);
      checkOutput({tag, ":e_op"},     alu_op, op);
      checkOutput({tag, ":e_imm"},    imm, w[3:0]);
      checkOutput({tag, ":e_we"},     {we_a, we_b, we_out}, 0);
      alu_carry = cin;
      tick;
      checkOutput({tag, ":w_we"},     {we_a, we_b, we_out}, model_we(op));
      checkOutput({tag, ":w_op"},     alu_op, op);
      checkOutput({tag, ":w_pc"},     pc, m_pc);
      checkOutput({tag, ":w_busy"},   busy, 1);
      checkOutput({tag, ":w_carry"},  carry_q, m_carry);
      if (op == 4'hF) m_pc = w[3:0];
      else if (op == 4'hE) m_pc = m_carry ? m_pc + 4'd1 : w[3:0];
      else m_pc = m_pc + 4'd1;
      if (op == 4'h4 || op == 4'h5) m_carry = cin;
      else if (op == 4'h1 || op == 4'h2 || op == 4'h3) m_carry = 1'b0;
      if (op == 4'h8) m_halted = 1'b1;
   endtask

   initial begin
      logic [9:0] w;
      logic       cin;
      logic       ra;
      logic       ss;
      int         k;
      total = 0;
      bad = 0;
      rst = 1'b1;
      run = 1'b0;
      step = 1'b0;
      alu_carry = 1'b0;
      m_pc = '0;
      m_carry = 1'b0;
      m_halted = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 10'b00_0000_0000;

      // MOV A from IN: write enable only in cycle 4, then pc=1.
      do_reset("movA");
      rom[0] = 10'b01_0001_0011;
      run = 1'b1;
      tick;
      applyStimulus(1'b0, 1'b0, 1'b0, "movA");
      tick;
      chk_idle("movA_after");

      // ADD with carry out, then JNC not taken.
      do_reset("jnc1");
      rom[0] = 10'b00_0100_1111;
      rom[1] = 10'b00_1110_0111;
      run = 1'b1;
      tick;
      applyStimulus(1'b1, 1'b1, 1'b0, "addA_c1");
      tick;
      applyStimulus(1'b0, 1'b0, 1'b0, "jnc_nt");
      tick;
      chk_idle("jnc_nt_after");

      // ADD without carry, then JNC taken to 7.
      do_reset("jnc0");
      run = 1'b1;
      tick;
      applyStimulus(1'b0, 1'b1, 1'b0, "addA_c0");
      tick;
      applyStimulus(1'b1, 1'b0, 1'b0, "jnc_t");
      tick;
      chk_idle("jnc_t_after");

      // JMP 15, NOP at 15 wraps to 0 with no extra cycle.
      do_reset("wrap");
      for (int i = 0; i < 16; i++) rom[i] = 10'b00_0000_0000;
      rom[0]  = 10'b00_1111_1111;
      rom[15] = 10'b00_0000_0101;
      run = 1'b1;
      tick;
      applyStimulus(1'b1, 1'b1, 1'b0, "jmp15");
      tick;
      applyStimulus(1'b0, 1'b1, 1'b0, "nop15");
      tick;
      applyStimulus(1'b0, 1'b0, 1'b0, "jmp_again");
      tick;
      chk_idle("wrap_after");

      // Single step, stray step during busy ignored, then run+step acts as run.
      do_reset("step");
      rom[0] = 10'b10_0010_0110;
      rom[1] = 10'b11_0011_0001;
      rom[2] = 10'b00_0000_0000;
      step = 1'b1;
      tick;
      step = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, "step1");
      tick;
      chk_idle("step1_idle");
      tick;
      chk_idle("step1_idle2");
      step = 1'b1;
      run = 1'b1;
      tick;
      step = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, "both");
      tick;
      applyStimulus(1'b0, 1'b0, 1'b0, "both_next");
      tick;
      chk_idle("both_after");

      // HLT at pc=3 parks with pc=4 and ignores run/step.
      do_reset("hlt");
      rom[0] = 10'b01_0001_0010;
      rom[1] = 10'b00_0101_1001;
      rom[2] = 10'b00_0000_0000;
      rom[3] = 10'b00_1000_0000;
      run = 1'b1;
      tick;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, "hlt_prog");
         tick;
      end
      for (int i = 0; i < 6; i++) begin
         checkOutput("halt_halted", halted, 1);
         checkOutput("halt_busy",   busy, 0);
         checkOutput("halt_rom_en", rom_en, 0);
         checkOutput("halt_pc",     pc, 4);
         checkOutput("halt_we",     {we_a, we_b, we_out}, 0);
         run = 1'($urandom);
         step = 1'($urandom);
         tick;
      end

      // Reset during EXEC of a MOV after carry was set.
      do_reset("rstmid");
      rom[0] = 10'b00_0100_0111;
      rom[1] = 10'b01_0001_0000;
      run = 1'b1;
      tick;
      applyStimulus(1'b1, 1'b1, 1'b0, "rstmid_add");
      tick;
      tick;
      tick;
      checkOutput("rstmid_exec_op", alu_op, 4'h1);
      rst = 1'b1;
      run = 1'b0;
      tick;
      checkOutput("rstmid_pc",    pc, 0);
      checkOutput("rstmid_we",    {we_a, we_b, we_out}, 0);
      checkOutput("rstmid_busy",  busy, 0);
      checkOutput("rstmid_carry", carry_q, 0);
      rst = 1'b0;
      m_pc = '0;
      m_carry = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_idle("rstmid_after");
      end

      // Random program with random carries, run drops and restarts.
      do_reset("rnd");
      for (int i = 0; i < 16; i++) begin
         w = 10'($urandom);
         if (w[7:4] == 4'h8) w[7:4] = 4'h4;
         rom[i] = w;
      end
      run = 1'b1;
      tick;
      for (int n = 0; n < 60; n++) begin
         cin = 1'($urandom);
         ra = ($urandom_range(0, 3) != 0);
         ss = ($urandom_range(0, 4) == 0);
         applyStimulus(cin, ra, ss, "rnd");
         tick;
         if (!ra) begin
            chk_idle("rnd_idle");
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
               tick;
               chk_idle("rnd_idle_wait");
            end
            if ($urandom_range(0, 1) == 1) step = 1'b1;
            else run = 1'b1;
            tick;
            step = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
